// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-to-1 multiplexer.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_CHANNELS = 8;
    localparam int unsigned DEF_DWELL_W  = 4;

    // Channel-index width; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// Auto-scan sequencer: steps the channel pointer after DWELL+1 captures per channel.
module mux_scan_seq
    import mux_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned SEL_W    = sel_width(CHANNELS),
    parameter int unsigned DWELL_W  = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cap,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   scan_ptr
);

    localparam logic [SEL_W-1:0]   LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [DWELL_W-1:0] CNT_MAX = '1;

    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [SEL_W-1:0]   ptr_nxt;

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_ptr  <= '0;
            dwell_cnt <= '0;
        end else begin
            scan_ptr  <= ptr_nxt;
            dwell_cnt <= cnt_nxt;
        end
    end

    // Direct mode parks the sequencer at channel 0; a count that overshot a
    // lowered DWELL runs to its natural wrap, which also advances the pointer.
    always_comb begin
        ptr_nxt = scan_ptr;
        cnt_nxt = dwell_cnt;
        if (mode == MODE_DIRECT) begin
            ptr_nxt = '0;
            cnt_nxt = '0;
        end else if (cap) begin
            if ((dwell_cnt == dwell) || (dwell_cnt == CNT_MAX)) begin
                cnt_nxt = '0;
                ptr_nxt = (scan_ptr == LAST_CH) ? '0 : scan_ptr + SEL_W'(1);
            end else begin
                cnt_nxt = dwell_cnt + DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/mux_nto1_seq.sv
// Registered N-to-1 multiplexer with VALID/READY output and auto-scan mode.
module mux_nto1_seq
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned SEL_W    = sel_width(CHANNELS),
    parameter int unsigned DWELL_W  = DEF_DWELL_W
) (
    input  logic                      CLK,
    input  logic                      RSTb,
    input  logic                      ENb,
    input  logic                      MODE,
    input  logic [SEL_W-1:0]          SEL,
    input  logic [DWELL_W-1:0]        DWELL,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic                      READY,
    output logic [WIDTH-1:0]          Y,
    output logic [WIDTH-1:0]          W,
    output logic [SEL_W-1:0]          CH,
    output logic                      VALID,
    output logic                      RANGE_ERR
);

    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

    logic             cap_c;
    logic             oob_c;
    logic [SEL_W-1:0] scan_ptr;
    logic [SEL_W-1:0] ch_c;
    logic [WIDTH-1:0] sel_data_c;

    logic [WIDTH-1:0] y_nxt;
    logic [WIDTH-1:0] w_nxt;
    logic [SEL_W-1:0] ch_nxt;
    logic             valid_nxt;
    logic             rerr_nxt;

    // A new sample is taken when enabled and the output slot is free or draining.
    assign cap_c = !ENb && (!VALID || READY);

    mux_scan_seq #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W),
        .DWELL_W  (DWELL_W)
    ) u_scan (
        .clk      (CLK),
        .rst_n    (RSTb),
        .cap      (cap_c),
        .mode     (MODE),
        .dwell    (DWELL),
        .scan_ptr (scan_ptr)
    );

    // Channel selection; an out-of-range direct select yields zero data.
    always_comb begin
        ch_c       = (MODE == MODE_SCAN) ? scan_ptr : SEL;
        oob_c      = (MODE == MODE_DIRECT) && ({1'b0, SEL} >= CH_LIM);
        sel_data_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!oob_c && (ch_c == SEL_W'(k))) begin
                sel_data_c = D[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output-stage next state: disable flushes, capture loads, otherwise hold.
    always_comb begin
        y_nxt     = Y;
        w_nxt     = W;
        ch_nxt    = CH;
        valid_nxt = VALID;
        rerr_nxt  = 1'b0;
        if (ENb) begin
            y_nxt     = '0;
            w_nxt     = '1;
            valid_nxt = 1'b0;
        end else if (cap_c) begin
            y_nxt     = sel_data_c;
            w_nxt     = ~sel_data_c;
            ch_nxt    = ch_c;
            valid_nxt = 1'b1;
            rerr_nxt  = oob_c;
        end
    end

    // Output register.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            Y         <= '0;
            W         <= '1;
            CH        <= '0;
            VALID     <= 1'b0;
            RANGE_ERR <= 1'b0;
        end else begin
            Y         <= y_nxt;
            W         <= w_nxt;
            CH        <= ch_nxt;
            VALID     <= valid_nxt;
            RANGE_ERR <= rerr_nxt;
        end
    end

endmodule

// File: doc/mux_nto1_seq.md
Name: mux_nto1_seq

Overview:
- Parametrised registered N-to-1 multiplexer; successor to the fixed 8:1 tree mux.
- Generalised in channel count and data width.
- Adds a registered output with a VALID/READY handshake and an auto-scan mode that steps through channels with a programmable dwell count.
- Feeds the ALU operand-select and debug/observation paths. True and inverted outputs are kept.

Parameters:
- WIDTH, 8, bits per data channel.
- CHANNELS, 8, number of input channels (>=2).
- SEL_W, $clog2(CHANNELS), select/channel-index width.
- DWELL_W, 4, width of the dwell programming field.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RSTb  input  1  synchronous active-low reset.
- ENb  input  1  active-low enable.
- MODE  input  1  0 = direct select, 1 = auto-scan.
- SEL  input  SEL_W  channel select in direct mode.
- DWELL  input  DWELL_W  extra samples per channel in scan mode (DWELL+1 samples each).
- D  input  CHANNELS*WIDTH  flattened data; channel k = D[k*WIDTH +: WIDTH].
- READY  input  1  downstream accepts Y this cycle.
- Y  output  WIDTH  registered selected data.
- W  output  WIDTH  always ~Y (registered alongside Y).
- CH  output  SEL_W  channel index that produced Y.
- VALID  output  1  Y/W/CH hold a sample.
- RANGE_ERR  output  1  one-cycle pulse: out-of-range direct select captured.

Behaviour:
- Reset (RSTb=0 at edge): Y=0, W=all ones, CH=0, VALID=0, RANGE_ERR=0, scan_ptr=0, dwell_cnt=0. Reset overrides every other input, including a pending sample, which is dropped.
- Capture condition: cap = !ENb && (!VALID || READY).
- On cap: Y<=D[ch], W<=~D[ch], CH<=ch, VALID<=1. Latency is 1 cycle from D/SEL to Y.
- Transfer: occurs when VALID && READY. With a transfer and cap in the same cycle, a new sample is loaded back-to-back, giving 1 sample/cycle throughput.
- Stall: VALID && !READY holds Y, W, CH, VALID, scan_ptr and dwell_cnt. Input changes are ignored.
- Disable: ENb=1 at an edge forces Y=0, W=all ones, VALID=0, RANGE_ERR=0 next cycle. Any unaccepted sample is dropped. scan_ptr and dwell_cnt hold.
- Direct mode (MODE=0):
  - ch=SEL.
  - If SEL>=CHANNELS at cap: Y<=0, W<=all ones, CH<=SEL, VALID<=1, RANGE_ERR<=1 for that cycle only.
  - scan_ptr and dwell_cnt are forced to 0 every cycle.
- Scan mode (MODE=1): ch=scan_ptr; SEL is ignored. On each cap:
  - dwell_cnt==DWELL: dwell_cnt<=0, and scan_ptr<=(scan_ptr==CHANNELS-1)?0:scan_ptr+1.
  - Otherwise: dwell_cnt<=dwell_cnt+1.
  - No cap means no advance.
- Mode entry: switching MODE 0->1 always starts at channel 0, dwell 0. Switching 1->0 takes effect at the next cap.
- DWELL changed mid-dwell: takes effect on the next compare. If dwell_cnt>DWELL, the count runs to wrap at 2^DWELL_W-1, then 0. That wrap condition also triggers the advance.
- Non-power-of-2 CHANNELS: scan wraps at CHANNELS-1 and never produces RANGE_ERR.

Decomposition:
- Package mux_pkg holds:
  - MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - Helper function sel_width(channels).
  - Default WIDTH/CHANNELS constants.
- Sub-module mux_scan_seq holds scan_ptr and dwell_cnt, with inputs cap/MODE/DWELL and output scan_ptr. The top level holds the channel mux, the output register and the handshake.

Test Plan:
1. Reset and direct select: RSTb=0 for 2 cycles, then ENb=0, MODE=0, READY=1, D[k]=8'h10+k, SEL=5 -> Y=8'h15, W=8'hEA, CH=5, VALID=1 one cycle later. Then SEL=2 next cycle -> Y=8'h12.
2. Stall: hold READY=0 for 3 cycles after VALID while changing SEL -> Y, CH and VALID frozen. READY=1 -> next sample loads the following cycle with no sample lost.
3. Scan with DWELL=1, CHANNELS=8, READY=1: CH sequence 0,0,1,1,...,7,7,0,0. Y tracks D[CH] throughout.
4. Scan with stall and mode change: READY=0 mid-dwell -> scan_ptr holds. MODE->0 then back to 1 -> scan restarts at CH=0.
5. Out of range with CHANNELS=6, SEL=7 -> Y=0, W=8'hFF, CH=7, RANGE_ERR high for exactly 1 cycle.
6. Disable and reset mid-operation: ENb=1 with VALID=1 -> next cycle VALID=0, Y=0. RSTb=0 during scan at CH=4 -> all outputs at reset values; the next scan starts at CH=0.
